cnn_pool: RTL and testbench
===========================

// Module: cnn_pool
// PURPOSE
//  Downstream of the convolution stage: consumes its per-channel result stream (conv_data/conv_valid)
//  and performs 2x2/stride-2 signed max pooling independently per output channel, using a per-channel
//  half-row line buffer. Presents pooled words with a valid/ready handshake and back-pressures the
//  convolution stage through its stall input. A bypass mode forwards every result unpooled.
// PARAMETERS
//  CH     4   output channels (equals conv WEIGHT_SIZE); one independent pooling lane per channel
//  DW     32  data width per channel word, two's complement
//  MAX_W  64  maximum input row width in pixels (even); line buffer depth per lane = MAX_W/2
// PORTS
//  clk          in   1        clock
//  rst          in   1        reset, synchronous, active-low
//  conf_refresh in   1        latch row_width/pool_en, clear lane state (asserted between layers only)
//  row_width    in   $clog2(MAX_W+1) input row width in pixels, sampled on conf_refresh
//  pool_en      in   1        1: 2x2 max pool, 0: bypass; sampled on conf_refresh
//  conv_data    in   CH*DW    per-channel results, lane i at [i*DW +: DW]
//  conv_valid   in   CH       per-channel valid; lanes arrive staggered, not aligned
//  stall        out  1        to conv stall input; = (|out_valid) & ~out_ready, combinational
//  out_data     out  CH*DW    pooled/bypassed words, lane i at [i*DW +: DW]
//  out_valid    out  CH       per-lane output valid
//  out_ready    in   1        consumer accepts all asserted out_valid lanes this cycle
// BEHAVIOUR
//  - Reset (rst=0 at posedge): out_valid=0, out_data=0, cfg width=2, pool_en=1, all col/row/hold state 0.
//    Line buffer contents need no reset. Reset mid-row discards partial windows.
//  - conf_refresh: width_q = clamp(row_width, 2, MAX_W); pool_en_q = pool_en; col=0, row_par=0,
//    out_valid=0 in all lanes. Priority over data: conv_valid in the same cycle is ignored.
//  - Accept lane i: fire_i = conv_valid[i] & ~stall & ~conf_refresh. Inputs with stall=1 are not consumed
//    (conv freezes and holds them).
//  - Lane state: col (0..width_q-1), row_par, hold (DW), lbuf[MAX_W/2] x DW.
//    On fire_i with x = lane data:
//      col even: hold <= x.
//      col odd, row_par=0: lbuf[col>>1] <= smax(hold,x); no output.
//      col odd, row_par=1: out_data_i <= smax(lbuf[col>>1], smax(hold,x)); out_valid_i <= 1.
//      col == width_q-1: col <= 0, row_par <= ~row_par; else col <= col+1.
//    Odd width_q: last (even-index) column of each row never pairs and is dropped.
//  - smax = signed DW-bit compare; ties return either (equal) value. No width growth.
//  - Bypass (pool_en_q=0): every fire_i loads out_data_i <= x, out_valid_i <= 1; counters idle.
//  - Latency: out_valid_i rises the cycle after the completing fire_i (1 cycle register).
//  - Output register per lane: if fire_i produces output -> load (regardless of old valid; fire implies
//    ~stall, i.e. old word accepted or absent). Else if out_ready -> out_valid_i <= 0. Else hold.
//    out_data stable while out_valid_i=1 and out_ready=0.
//  - Simultaneous out_ready=1 and new output in a lane: old word taken, new word loaded, valid stays 1.
//  - stall is global: any pending lane with out_ready=0 blocks all lanes.
//  - Lanes never interact except via stall; each lane's col/row_par advance only on its own fire_i.
// TESTING
//  1 width=4, pool_en=1, lane0 rows {1,5,2,3},{4,0,-7,9} -> out_valid[0] twice: 5 then 9; lane0 only.
//  2 all negatives: rows {-8,-3,-5,-6},{-4,-9,-2,-1} -> outputs -3, -1 (signed compare, not unsigned).
//  3 out_ready=0 when first pooled word pending, conv_valid held high -> stall=1 same cycle, no inputs
//    consumed, out_data unchanged; out_ready=1 -> stall=0, pending input accepted next edge, stream intact.
//  4 pool_en=0, CH=4 staggered valids, values 10..13 -> each lane echoes its value 1 cycle later.
//  5 width=5: rows {1,2,3,4,99},{5,6,7,8,99} -> outputs 6, 8 only; 99 never appears; row_par toggles per 5.
//  6 rst=0 mid-row (after 3 pixels) then width=4 stream -> out_valid=0 during reset, first output
//    computed only from post-reset pixels; conf_refresh with conv_valid=1 -> that input ignored.

Source files
------------

// File: rtl/cnn_pool.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// cnn_pool : per-channel 2x2/stride-2 signed max pooling with bypass.
// Revision : 1.0
// ============================================================================
module cnn_pool #(
  parameter int CH    = 4,
  parameter int DW    = 32,
  parameter int MAX_W = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         conf_refresh,
  input  logic [$clog2(MAX_W+1)-1:0]   row_width,
  input  logic                         pool_en,
  input  logic [CH*DW-1:0]             conv_data,
  input  logic [CH-1:0]                conv_valid,
  output logic                         stall,
  output logic [CH*DW-1:0]             out_data,
  output logic [CH-1:0]                out_valid,
  input  logic                         out_ready
);

  localparam int WW = $clog2(MAX_W + 1);
  localparam int CW = $clog2(MAX_W);
  localparam logic [WW-1:0] W_MIN = WW'(2);
  localparam logic [WW-1:0] W_MAX = WW'(MAX_W);

  function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [WW-1:0] width_q, width_d, last_col;
  logic          pool_en_q;

  always_comb begin
    width_d = row_width;
    if (row_width < W_MIN)      width_d = W_MIN;
    else if (row_width > W_MAX) width_d = W_MAX;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      width_q   <= W_MIN;
      pool_en_q <= 1'b1;
    end else if (conf_refresh) begin
      width_q   <= width_d;
      pool_en_q <= pool_en;
    end
  end

  assign last_col = width_q - WW'(1);
  assign stall    = (|out_valid) & ~out_ready;

  for (genvar i = 0; i < CH; i++) begin : g_lane
    logic [CW-1:0]          col_q, col_d;
    logic                   par_q, par_d;
    logic signed [DW-1:0]   hold_q, hold_d, od_q, od_d, x, pair, lbuf_rd;
    logic                   ov_q, ov_d, fire, lb_we;
    logic signed [DW-1:0]   lbuf [MAX_W/2];

    assign x       = conv_data[i*DW +: DW];
    assign fire    = conv_valid[i] & ~stall & ~conf_refresh;
    assign pair    = smax(hold_q, x);
    assign lbuf_rd = lbuf[col_q[CW-1:1]];

    always_comb begin
      col_d  = col_q;
      par_d  = par_q;
      hold_d = hold_q;
      od_d   = od_q;
      ov_d   = ov_q;
      lb_we  = 1'b0;
      if (conf_refresh) begin
        col_d = '0;
        par_d = 1'b0;
        ov_d  = 1'b0;
      end else if (fire && !pool_en_q) begin
        od_d = x;
        ov_d = 1'b1;
      end else if (fire) begin
        // Odd columns close a horizontal pair; second row of the pair emits.
        if (!col_q[0]) begin
          hold_d = x;
          if (out_ready) ov_d = 1'b0;
        end else if (!par_q) begin
          lb_we = 1'b1;
          if (out_ready) ov_d = 1'b0;
        end else begin
          od_d = smax(lbuf_rd, pair);
          ov_d = 1'b1;
        end
        if (WW'(col_q) == last_col) begin
          col_d = '0;
          par_d = ~par_q;
        end else begin
          col_d = col_q + CW'(1);
        end
      end else if (out_ready) begin
        ov_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        col_q  <= '0;
        par_q  <= 1'b0;
        hold_q <= '0;
        od_q   <= '0;
        ov_q   <= 1'b0;
      end else begin
        col_q  <= col_d;
        par_q  <= par_d;
        hold_q <= hold_d;
        od_q   <= od_d;
        ov_q   <= ov_d;
      end
    end

    // Line buffer is storage only; stale contents are always overwritten before use.
    always_ff @(posedge clk) begin
      if (rst && lb_we) lbuf[col_q[CW-1:1]] <= pair;
    end

    assign out_data[i*DW +: DW] = od_q;
    assign out_valid[i]         = ov_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_cnn_pool.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_cnn_pool : directed self-checking bench for cnn_pool.
// Revision    : 1.0
// ============================================================================
module tb_cnn_pool;
  localparam int CH = 4, DW = 32, MAX_W = 8, WW = $clog2(MAX_W + 1);

  logic              clk = 1'b0;
  logic              rst, conf_refresh, pool_en, out_ready, stall;
  logic [WW-1:0]     row_width;
  logic [CH*DW-1:0]  conv_data, out_data;
  logic [CH-1:0]     conv_valid, out_valid;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  cnn_pool #(.CH(CH), .DW(DW), .MAX_W(MAX_W)) dut (
    .clk(clk), .rst(rst), .conf_refresh(conf_refresh), .row_width(row_width),
    .pool_en(pool_en), .conv_data(conv_data), .conv_valid(conv_valid),
    .stall(stall), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  function automatic int lane_data(input int l);
    return int'($signed(out_data[l*DW +: DW]));
  endfunction

  task automatic push(input int lane, input int v);
    conv_valid = '0;
    conv_valid[lane] = 1'b1;
    conv_data[lane*DW +: DW] = v;
    @(negedge clk);
    conv_valid = '0;
  endtask

  task automatic cfg(input int w, input logic pe);
    conf_refresh = 1'b1;
    row_width    = WW'(w);
    pool_en      = pe;
    @(negedge clk);
    conf_refresh = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b want 0000", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    rst = 1'b1;
    push(0, 3); push(0, 7);
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_w2_row0: got %b want 0000", out_valid); end
    push(0, 1); push(0, 2);
    checks++; if (out_valid !== 4'b0001 || lane_data(0) !== 7) begin
      errors++; $display("FAIL reset_w2_out: valid %b data %0d want 0001 7", out_valid, lane_data(0)); end
  endtask

  task automatic test_pool();
    cfg(4, 1'b1);
    push(0, 1); push(0, 5); push(0, 2); push(0, 3);
    push(0, 4); push(0, 0);
    checks++; if (out_valid !== 4'b0001 || lane_data(0) !== 5) begin
      errors++; $display("FAIL pool_first: valid %b data %0d want 0001 5", out_valid, lane_data(0)); end
    push(0, -7);
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL pool_clear: got %b want 0000", out_valid); end
    push(0, 9);
    checks++; if (out_valid !== 4'b0001 || lane_data(0) !== 9) begin
      errors++; $display("FAIL pool_second: valid %b data %0d want 0001 9", out_valid, lane_data(0)); end
    @(negedge clk);
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL pool_idle: got %b want 0000", out_valid); end
  endtask

  task automatic test_negative();
    cfg(4, 1'b1);
    push(2, -8); push(2, -3); push(2, -5); push(2, -6);
    push(2, -4); push(2, -9);
    checks++; if (out_valid !== 4'b0100 || lane_data(2) !== -3) begin
      errors++; $display("FAIL neg_first: valid %b data %0d want 0100 -3", out_valid, lane_data(2)); end
    push(2, -2); push(2, -1);
    checks++; if (out_valid !== 4'b0100 || lane_data(2) !== -1) begin
      errors++; $display("FAIL neg_second: valid %b data %0d want 0100 -1", out_valid, lane_data(2)); end
  endtask

  task automatic test_stall();
    cfg(4, 1'b1);
    out_ready = 1'b0;
    push(1, 1); push(1, 2); push(1, 3); push(1, 4);
    push(1, 5); push(1, 6);
    checks++; if (out_valid !== 4'b0010 || lane_data(1) !== 6) begin
      errors++; $display("FAIL stall_first: valid %b data %0d want 0010 6", out_valid, lane_data(1)); end
    conv_valid = 4'b0010;
    conv_data[1*DW +: DW] = 7;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_assert: got %b want 1", stall); end
    @(negedge clk); @(negedge clk);
    checks++; if (out_valid !== 4'b0010 || lane_data(1) !== 6) begin
      errors++; $display("FAIL stall_hold: valid %b data %0d want 0010 6", out_valid, lane_data(1)); end
    out_ready = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_release: got %b want 0", stall); end
    @(negedge clk);
    conv_valid = '0;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL stall_drain: got %b want 0000", out_valid); end
    push(1, 8);
    checks++; if (out_valid !== 4'b0010 || lane_data(1) !== 8) begin
      errors++; $display("FAIL stall_resume: valid %b data %0d want 0010 8", out_valid, lane_data(1)); end
  endtask

  task automatic test_bypass();
    cfg(4, 1'b0);
    for (int i = 0; i < CH; i++) begin
      push(i, 10 + i);
      checks++; if (out_valid !== CH'(1 << i) || lane_data(i) !== 10 + i) begin
        errors++; $display("FAIL bypass_lane%0d: valid %b data %0d want %0d", i, out_valid, lane_data(i), 10 + i); end
    end
    @(negedge clk);
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL bypass_idle: got %b want 0000", out_valid); end
  endtask

  task automatic test_odd_width();
    cfg(5, 1'b1);
    push(3, 1); push(3, 2); push(3, 3); push(3, 4); push(3, 99);
    push(3, 5); push(3, 6);
    checks++; if (out_valid !== 4'b1000 || lane_data(3) !== 6) begin
      errors++; $display("FAIL odd_first: valid %b data %0d want 1000 6", out_valid, lane_data(3)); end
    push(3, 7); push(3, 8);
    checks++; if (out_valid !== 4'b1000 || lane_data(3) !== 8) begin
      errors++; $display("FAIL odd_second: valid %b data %0d want 1000 8", out_valid, lane_data(3)); end
    push(3, 99);
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL odd_drop: got %b want 0000", out_valid); end
    push(3, 100); push(3, 100);
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL odd_rowpar: got %b want 0000", out_valid); end
  endtask

  task automatic test_clamp();
    cfg(1, 1'b1);
    push(2, 3); push(2, 7); push(2, 1); push(2, 2);
    checks++; if (out_valid !== 4'b0100 || lane_data(2) !== 7) begin
      errors++; $display("FAIL clamp_low: valid %b data %0d want 0100 7", out_valid, lane_data(2)); end
    cfg(15, 1'b1);
    for (int i = 1; i <= 8; i++) push(1, i);
    push(1, 0); push(1, 0);
    checks++; if (out_valid !== 4'b0010 || lane_data(1) !== 2) begin
      errors++; $display("FAIL clamp_high: valid %b data %0d want 0010 2", out_valid, lane_data(1)); end
  endtask

  task automatic test_reset_midrow();
    cfg(4, 1'b1);
    push(0, 1); push(0, 2); push(0, 3);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 4'b0000 || lane_data(0) !== 0) begin
      errors++; $display("FAIL midrst_clear: valid %b data %0d want 0000 0", out_valid, lane_data(0)); end
    rst = 1'b1;
    conv_valid = 4'b0001;
    conv_data[0 +: DW] = 1000;
    cfg(4, 1'b1);
    conv_valid = '0;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL midrst_cfg: got %b want 0000", out_valid); end
    push(0, 10); push(0, 20); push(0, 30); push(0, 40);
    push(0, 1); push(0, 2);
    checks++; if (out_valid !== 4'b0001 || lane_data(0) !== 20) begin
      errors++; $display("FAIL midrst_first: valid %b data %0d want 0001 20", out_valid, lane_data(0)); end
    push(0, 3); push(0, 4);
    checks++; if (out_valid !== 4'b0001 || lane_data(0) !== 40) begin
      errors++; $display("FAIL midrst_second: valid %b data %0d want 0001 40", out_valid, lane_data(0)); end
  endtask

  initial begin
    rst = 1'b0; conf_refresh = 1'b0; pool_en = 1'b1; out_ready = 1'b1;
    row_width = '0; conv_data = '0; conv_valid = '0;
    @(negedge clk);
    test_reset();
    test_pool();
    test_negative();
    test_stall();
    test_bypass();
    test_odd_width();
    test_clamp();
    test_reset_midrow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
